tow_round_sched: RTL and testbench
==================================

Name: tow_round_sched

Overview:
Round scheduler for the tug-of-war game. It sequences each round: a random hold-off, then arming the lights, then judging the first push (or a false start). It issues point, tie and clear strobes to the scorer path, selects the LED mux mode, and keeps a best-of-N match tally. It sits between the synchronized push pulses / div256 / lfsr and the scorer / led_mux.

Parameters:
WIN_ROUNDS, 3, round wins needed to take the match (1..7)
MIN_WAIT, 4, minimum hold-off in slowen ticks before lights arm (>=1)
RWAIT_BITS, 3, width of random extra hold-off (0..2^RWAIT_BITS-1 ticks)
SHOW_TICKS, 8, slowen ticks the round result is displayed

Ports:
clk  in  1  system clock (divided clock domain)
rst  in  1  synchronous active-high reset
slowen  in  1  one-cycle tick from div256
rand  in  1  lfsr serial random bit
push_l  in  1  synchronized one-cycle left push pulse
push_r  in  1  synchronized one-cycle right push pulse
leds_on  out  1  lights armed; players may push
clr  out  1  one-cycle round-start clear to scorer/push logic
pt_l  out  1  one-cycle point to left
pt_r  out  1  one-cycle point to right
tie  out  1  one-cycle simultaneous-push strobe
led_ctrl  out  2  mux mode: 00 blank, 01 score, 10 flash winner, 11 all on
wins_l  out  3  left round wins
wins_r  out  3  right round wins
match_over  out  1  level: match decided
winner_r  out  1  valid when match_over: 1 = right won

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=START; all strobes 0; leds_on=0; led_ctrl=00; wins_l=wins_r=0; match_over=0; winner_r=0; rnd shift reg=0; counter=0. Reset overrides every other event, in any state.
- rnd register: RWAIT_BITS shift register, shifts in rand every clk (including in reset-exit cycle onward).
- States:
  - START: one cycle; clr=1; load cnt=MIN_WAIT+rnd; led_ctrl=01; go WAIT.
  - WAIT: leds_on=0; cnt decrements on slowen; on slowen with cnt==1, go ARMED (leds_on=1 next cycle).
    - False start, push_l only: pt_r=1 next cycle, go SHOW.
    - False start, push_r only: pt_l=1 next cycle, go SHOW.
    - Both in same cycle: no point; go START (replay).
    - A push in the same cycle as the final slowen counts as a false start.
  - ARMED: leds_on=1; wait indefinitely.
    - push_l only: pt_l.
    - push_r only: pt_r.
    - Both same cycle: tie=1, no point.
    - In all three cases go SHOW.
  - SHOW: leds_on=0; led_ctrl=10; cnt=SHOW_TICKS, decremented on slowen; pushes ignored. At expiry:
    - If a tally has reached WIN_ROUNDS, go OVER.
    - Otherwise go START.
  - OVER: match_over=1; led_ctrl=11 toggles to 10 on every slowen (flash); pushes ignored. Exit only via rst.
- Strobes are exactly one clk wide and registered: 1 cycle after the deciding push edge.
- Tally: wins_x increments in the same cycle as pt_x. Saturates at WIN_ROUNDS; no wrap. winner_r is set from the tally that reached WIN_ROUNDS.
- Round latency: START→ARMED = 1 + (MIN_WAIT+rnd) slowen ticks.

Test Plan:
- Reset mid-ARMED with wins_l=2 → next cycle: state START path, wins 0/0, leds_on=0, all strobes 0, then clr pulse 1 cycle after rst deasserts.
- Force rand=0 (rnd=0), MIN_WAIT=4 → leds_on rises exactly 1 cycle after 4th slowen following clr; push_r 3 cycles later → pt_r 1 cycle, wins_r=1, led_ctrl=10 for 8 slowen ticks, then clr.
- push_l during WAIT → pt_r=1 (false start penalty), wins_r=1, leds_on never asserted that round.
- push_l and push_r same cycle in ARMED → tie=1 one cycle, no tally change; same in WAIT → no tie, immediate clr replay.
- Right wins 3 rounds (WIN_ROUNDS=3) → after SHOW: match_over=1, winner_r=1, led_ctrl alternates 11/10 per slowen; further pushes change nothing; wins_r stays 3.
- Random hold-off: sweep lfsr seeds → measured WAIT length always in [MIN_WAIT, MIN_WAIT+7] ticks and not constant across rounds.

Source files
------------

// File: rtl/tow_round_sched_if.sv
// rtl/tow_round_sched_if.sv - round scheduler signal bundle: tick/random/push inputs, strobes and tally outputs
interface tow_round_sched_if;
   logic       slowen;
   logic       rand_bit;
   logic       push_l;
   logic       push_r;
   logic       leds_on;
   logic       clr;
   logic       pt_l;
   logic       pt_r;
   logic       tie;
   logic [1:0] led_ctrl;
   logic [2:0] wins_l;
   logic [2:0] wins_r;
   logic       match_over;
   logic       winner_r;

   modport master (
      output slowen, rand_bit, push_l, push_r,
      input  leds_on, clr, pt_l, pt_r, tie, led_ctrl, wins_l, wins_r, match_over, winner_r
   );

   modport slave (
      input  slowen, rand_bit, push_l, push_r,
      output leds_on, clr, pt_l, pt_r, tie, led_ctrl, wins_l, wins_r, match_over, winner_r
   );
endinterface

// File: rtl/tow_round_sched.sv
// rtl/tow_round_sched.sv - tug-of-war round sequencer: random hold-off, arm, judge first push, best-of-N tally
module tow_round_sched #(
   parameter int WIN_ROUNDS = 3,
   parameter int MIN_WAIT   = 4,
   parameter int RWAIT_BITS = 3,
   parameter int SHOW_TICKS = 8
) (
   input  logic             clk,
   input  logic             rst,
   tow_round_sched_if.slave bus
);
   localparam int RND_MAX = (1 << RWAIT_BITS) - 1;
   localparam int CNT_MAX = (MIN_WAIT + RND_MAX > SHOW_TICKS) ? (MIN_WAIT + RND_MAX) : SHOW_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [2:0] WIN = 3'(WIN_ROUNDS);

   typedef enum logic [2:0] {
      S_START,
      S_WAIT,
      S_ARMED,
      S_SHOW,
      S_OVER
   } state_t;

   state_t                state, state_next;
   logic [CNT_W-1:0]      cnt, cnt_next;
   logic [RWAIT_BITS-1:0] rnd;

   logic       leds_on_q, clr_q, pt_l_q, pt_r_q, tie_q, match_over_q, winner_r_q;
   logic       clr_next, pt_l_next, pt_r_next, tie_next, match_over_next, winner_r_next;
   logic [1:0] led_ctrl_q, led_ctrl_next;
   logic [2:0] wins_l_q, wins_r_q, wins_l_next, wins_r_next;

   logic push_l_only, push_r_only, push_both;

   assign push_l_only = bus.push_l & ~bus.push_r;
   assign push_r_only = bus.push_r & ~bus.push_l;
   assign push_both   = bus.push_l & bus.push_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_START;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next      = state;
      cnt_next        = cnt;
      clr_next        = 1'b0;
      pt_l_next       = 1'b0;
      pt_r_next       = 1'b0;
      tie_next        = 1'b0;
      led_ctrl_next   = led_ctrl_q;
      wins_l_next     = wins_l_q;
      wins_r_next     = wins_r_q;
      match_over_next = match_over_q;
      winner_r_next   = winner_r_q;

      case (state)
         S_START: begin
            clr_next      = 1'b1;
            cnt_next      = CNT_W'(MIN_WAIT) + CNT_W'(rnd);
            led_ctrl_next = 2'b01;
            state_next    = S_WAIT;
         end
         S_WAIT: begin
            // a push landing on the final tick is still judged as a false start
            if (push_both) begin
               state_next = S_START;
            end else if (push_l_only) begin
               pt_r_next  = 1'b1;
               state_next = S_SHOW;
            end else if (push_r_only) begin
               pt_l_next  = 1'b1;
               state_next = S_SHOW;
            end else if (bus.slowen) begin
               cnt_next = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state_next = S_ARMED;
               end
            end
         end
         S_ARMED: begin
            if (push_both) begin
               tie_next   = 1'b1;
               state_next = S_SHOW;
            end else if (push_l_only) begin
               pt_l_next  = 1'b1;
               state_next = S_SHOW;
            end else if (push_r_only) begin
               pt_r_next  = 1'b1;
               state_next = S_SHOW;
            end
         end
         S_SHOW: begin
            if (bus.slowen) begin
               cnt_next = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  if (wins_l_q == WIN || wins_r_q == WIN) begin
                     state_next      = S_OVER;
                     match_over_next = 1'b1;
                     winner_r_next   = (wins_r_q == WIN);
                     led_ctrl_next   = 2'b11;
                  end else begin
                     state_next = S_START;
                  end
               end
            end
         end
         S_OVER: begin
            if (bus.slowen) begin
               led_ctrl_next = {1'b1, ~led_ctrl_q[0]};
            end
         end
         default: begin
            state_next = S_START;
         end
      endcase

      if (state_next == S_SHOW && state != S_SHOW) begin
         cnt_next      = CNT_W'(SHOW_TICKS);
         led_ctrl_next = 2'b10;
      end

      // tally moves on the same edge as the point strobe and never passes the match target
      if (pt_l_next && wins_l_q < WIN) begin
         wins_l_next = wins_l_q + 3'd1;
      end
      if (pt_r_next && wins_r_q < WIN) begin
         wins_r_next = wins_r_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         rnd          <= '0;
         leds_on_q    <= 1'b0;
         clr_q        <= 1'b0;
         pt_l_q       <= 1'b0;
         pt_r_q       <= 1'b0;
         tie_q        <= 1'b0;
         led_ctrl_q   <= 2'b00;
         wins_l_q     <= 3'd0;
         wins_r_q     <= 3'd0;
         match_over_q <= 1'b0;
         winner_r_q   <= 1'b0;
      end else begin
         cnt          <= cnt_next;
         rnd          <= RWAIT_BITS'({rnd, bus.rand_bit});
         leds_on_q    <= (state_next == S_ARMED);
         clr_q        <= clr_next;
         pt_l_q       <= pt_l_next;
         pt_r_q       <= pt_r_next;
         tie_q        <= tie_next;
         led_ctrl_q   <= led_ctrl_next;
         wins_l_q     <= wins_l_next;
         wins_r_q     <= wins_r_next;
         match_over_q <= match_over_next;
         winner_r_q   <= winner_r_next;
      end
   end

   assign bus.leds_on    = leds_on_q;
   assign bus.clr        = clr_q;
   assign bus.pt_l       = pt_l_q;
   assign bus.pt_r       = pt_r_q;
   assign bus.tie        = tie_q;
   assign bus.led_ctrl   = led_ctrl_q;
   assign bus.wins_l     = wins_l_q;
   assign bus.wins_r     = wins_r_q;
   assign bus.match_over = match_over_q;
   assign bus.winner_r   = winner_r_q;
endmodule

// File: tb/tb_tow_round_sched.sv
// tb/tb_tow_round_sched.sv - self-checking bench for tow_round_sched with random ticks/random bits and a round model
module tb_tow_round_sched;
   localparam int WIN_ROUNDS = 3;
   localparam int MIN_WAIT   = 4;
   localparam int RWAIT_BITS = 3;
   localparam int SHOW_TICKS = 8;
   localparam int BUDGET     = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;
   bit   rand_zero = 1'b1;
   int   hist = 0;
   int   snap_rnd = 0;
   int   exp_wl = 0;
   int   exp_wr = 0;

   tow_round_sched_if bus();

   tow_round_sched #(
      .WIN_ROUNDS(WIN_ROUNDS),
      .MIN_WAIT  (MIN_WAIT),
      .RWAIT_BITS(RWAIT_BITS),
      .SHOW_TICKS(SHOW_TICKS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // hold-off model: value of the last RWAIT_BITS random bits seen before each round-start edge
   always begin
      bus.slowen   = 1'b0;
      bus.rand_bit = 1'b0;
      forever begin
         @(posedge clk);
         snap_rnd = hist;
         hist = rst ? 0 : ((hist * 2) + int'(bus.rand_bit)) % (1 << RWAIT_BITS);
         #1;
         bus.slowen   = ($urandom_range(0, 2) == 0);
         bus.rand_bit = rand_zero ? 1'b0 : 1'($urandom_range(0, 1));
      end
   end

   task automatic pulse(input logic l, input logic r);
      bus.push_l = l;
      bus.push_r = r;
      @(negedge clk);
      bus.push_l = 1'b0;
      bus.push_r = 1'b0;
   endtask

   task automatic wait_clr(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         if (bus.clr === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_armed(output int n, output int exp_n, output bit last, output bit clr_long, output bit ok);
      exp_n = MIN_WAIT + snap_rnd;
      n = 0; last = 1'b0; clr_long = 1'b0; ok = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         if (bus.leds_on === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (i > 0 && bus.clr !== 1'b0) clr_long = 1'b1;
         n += int'(bus.slowen);
         last = bus.slowen;
         @(negedge clk);
      end
   endtask

   task automatic wait_show(output int ticks, output int gap, output bit extra, output bit ok);
      ticks = 0; gap = 0; extra = 1'b0; ok = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         if (bus.clr === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (i > 0 && (bus.pt_l | bus.pt_r | bus.tie) !== 1'b0) extra = 1'b1;
         if (bus.led_ctrl !== 2'b10 || bus.leds_on !== 1'b0) extra = 1'b1;
         if (ticks == SHOW_TICKS) gap++;
         else if (bus.slowen) ticks++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if ({bus.leds_on, bus.clr, bus.pt_l, bus.pt_r, bus.tie} !== 5'b0) $display("FAIL reset_strobes: got %b want 00000", {bus.leds_on, bus.clr, bus.pt_l, bus.pt_r, bus.tie}); else passed++;
      total++; if (bus.led_ctrl !== 2'b00) $display("FAIL reset_led_ctrl: got %b want 00", bus.led_ctrl); else passed++;
      total++; if ({bus.wins_l, bus.wins_r} !== 6'd0) $display("FAIL reset_wins: got %0d/%0d want 0/0", bus.wins_l, bus.wins_r); else passed++;
      total++; if ({bus.match_over, bus.winner_r} !== 2'b00) $display("FAIL reset_match: got %b want 00", {bus.match_over, bus.winner_r}); else passed++;
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.clr !== 1'b1) $display("FAIL reset_exit_clr: got %b want 1", bus.clr); else passed++;
      total++; if (bus.led_ctrl !== 2'b01) $display("FAIL start_led_ctrl: got %b want 01", bus.led_ctrl); else passed++;
   endtask

   task automatic test_armed_win();
      int n, e, ticks, gap; bit last, clr_long, ok, extra;
      wait_armed(n, e, last, clr_long, ok);
      total++; if (!ok) $display("FAIL armed_timeout: leds_on never rose"); else passed++;
      total++; if (n !== MIN_WAIT) $display("FAIL armed_holdoff: got %0d ticks want %0d", n, MIN_WAIT); else passed++;
      total++; if (last !== 1'b1) $display("FAIL armed_latency: cycle before leds_on slowen=%b want 1", last); else passed++;
      total++; if (clr_long !== 1'b0) $display("FAIL clr_width: got >1 cycle want 1"); else passed++;
      repeat (3) @(negedge clk);
      total++; if (bus.leds_on !== 1'b1) $display("FAIL armed_hold: leds_on=%b want 1", bus.leds_on); else passed++;
      pulse(1'b0, 1'b1);
      exp_wr++;
      total++; if ({bus.pt_l, bus.pt_r, bus.tie} !== 3'b010) $display("FAIL armed_pt_r: got %b want 010", {bus.pt_l, bus.pt_r, bus.tie}); else passed++;
      total++; if (bus.wins_r !== 3'(exp_wr) || bus.wins_l !== 3'(exp_wl)) $display("FAIL armed_tally: got %0d/%0d want %0d/%0d", bus.wins_l, bus.wins_r, exp_wl, exp_wr); else passed++;
      total++; if (bus.led_ctrl !== 2'b10 || bus.leds_on !== 1'b0) $display("FAIL show_entry: led_ctrl=%b leds_on=%b want 10/0", bus.led_ctrl, bus.leds_on); else passed++;
      wait_show(ticks, gap, extra, ok);
      total++; if (!ok) $display("FAIL show_timeout: clr never followed"); else passed++;
      total++; if (ticks !== SHOW_TICKS || gap !== 1) $display("FAIL show_length: got %0d ticks gap %0d want %0d gap 1", ticks, gap, SHOW_TICKS); else passed++;
      total++; if (extra !== 1'b0) $display("FAIL show_quiet: got extra strobe/led activity want none"); else passed++;
   endtask

   task automatic test_false_start();
      int ticks, gap; bit extra, ok;
      @(negedge clk);
      pulse(1'b1, 1'b0);
      exp_wr++;
      total++; if ({bus.pt_l, bus.pt_r, bus.tie, bus.leds_on} !== 4'b0100) $display("FAIL false_l: got %b want 0100", {bus.pt_l, bus.pt_r, bus.tie, bus.leds_on}); else passed++;
      total++; if (bus.wins_r !== 3'(exp_wr)) $display("FAIL false_l_tally: got %0d want %0d", bus.wins_r, exp_wr); else passed++;
      wait_show(ticks, gap, extra, ok);
      total++; if (!ok || extra) $display("FAIL false_l_show: ok=%b extra=%b want 1/0", ok, extra); else passed++;
      pulse(1'b0, 1'b1);
      exp_wl++;
      total++; if ({bus.pt_l, bus.pt_r, bus.tie, bus.leds_on} !== 4'b1000) $display("FAIL false_r: got %b want 1000", {bus.pt_l, bus.pt_r, bus.tie, bus.leds_on}); else passed++;
      total++; if (bus.wins_l !== 3'(exp_wl) || bus.wins_r !== 3'(exp_wr)) $display("FAIL false_r_tally: got %0d/%0d want %0d/%0d", bus.wins_l, bus.wins_r, exp_wl, exp_wr); else passed++;
      wait_show(ticks, gap, extra, ok);
      total++; if (!ok || extra) $display("FAIL false_r_show: ok=%b extra=%b want 1/0", ok, extra); else passed++;
   endtask

   task automatic test_tie();
      int n, e, ticks, gap; bit last, clr_long, ok, extra;
      wait_armed(n, e, last, clr_long, ok);
      total++; if (!ok || n !== e) $display("FAIL tie_holdoff: ok=%b got %0d want %0d", ok, n, e); else passed++;
      pulse(1'b1, 1'b1);
      total++; if ({bus.pt_l, bus.pt_r, bus.tie} !== 3'b001) $display("FAIL tie_armed: got %b want 001", {bus.pt_l, bus.pt_r, bus.tie}); else passed++;
      total++; if (bus.wins_l !== 3'(exp_wl) || bus.wins_r !== 3'(exp_wr)) $display("FAIL tie_tally: got %0d/%0d want %0d/%0d", bus.wins_l, bus.wins_r, exp_wl, exp_wr); else passed++;
      wait_show(ticks, gap, extra, ok);
      total++; if (!ok || extra) $display("FAIL tie_show: ok=%b extra=%b want 1/0", ok, extra); else passed++;
      pulse(1'b1, 1'b1);
      total++; if ({bus.pt_l, bus.pt_r, bus.tie, bus.clr} !== 4'b0000) $display("FAIL wait_both: got %b want 0000", {bus.pt_l, bus.pt_r, bus.tie, bus.clr}); else passed++;
      @(negedge clk);
      total++; if (bus.clr !== 1'b1) $display("FAIL wait_both_replay: clr=%b want 1", bus.clr); else passed++;
      total++; if (bus.wins_l !== 3'(exp_wl) || bus.wins_r !== 3'(exp_wr)) $display("FAIL wait_both_tally: got %0d/%0d want %0d/%0d", bus.wins_l, bus.wins_r, exp_wl, exp_wr); else passed++;
   endtask

   task automatic test_reset_mid_armed();
      int n, e, ticks, gap; bit last, clr_long, ok, extra;
      wait_armed(n, e, last, clr_long, ok);
      pulse(1'b1, 1'b0);
      exp_wl++;
      total++; if (bus.pt_l !== 1'b1 || bus.wins_l !== 3'(exp_wl)) $display("FAIL left_win: pt_l=%b wins_l=%0d want 1/%0d", bus.pt_l, bus.wins_l, exp_wl); else passed++;
      wait_show(ticks, gap, extra, ok);
      wait_armed(n, e, last, clr_long, ok);
      total++; if (!ok) $display("FAIL rst_armed_timeout: leds_on never rose"); else passed++;
      rst = 1'b1;
      @(negedge clk);
      exp_wl = 0; exp_wr = 0;
      total++; if ({bus.leds_on, bus.clr, bus.pt_l, bus.pt_r, bus.tie} !== 5'b0) $display("FAIL rst_mid_strobes: got %b want 00000", {bus.leds_on, bus.clr, bus.pt_l, bus.pt_r, bus.tie}); else passed++;
      total++; if ({bus.wins_l, bus.wins_r} !== 6'd0 || bus.led_ctrl !== 2'b00) $display("FAIL rst_mid_state: wins %0d/%0d led %b want 0/0 00", bus.wins_l, bus.wins_r, bus.led_ctrl); else passed++;
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.clr !== 1'b1) $display("FAIL rst_mid_clr: got %b want 1", bus.clr); else passed++;
   endtask

   task automatic test_final_tick_false_start();
      int cnt, e, ticks, gap; bit done, saw_leds, extra, ok;
      e = MIN_WAIT + snap_rnd;
      cnt = 0; done = 1'b0; saw_leds = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         if (bus.leds_on === 1'b1) begin
            saw_leds = 1'b1;
            break;
         end
         if (cnt == e - 1 && bus.slowen === 1'b1) begin
            pulse(1'b1, 1'b0);
            done = 1'b1;
            break;
         end
         cnt += int'(bus.slowen);
         @(negedge clk);
      end
      exp_wr++;
      total++; if (!done || saw_leds) $display("FAIL final_tick_reach: done=%b leds=%b want 1/0", done, saw_leds); else passed++;
      total++; if ({bus.pt_l, bus.pt_r, bus.leds_on} !== 3'b010) $display("FAIL final_tick_false: got %b want 010", {bus.pt_l, bus.pt_r, bus.leds_on}); else passed++;
      total++; if (bus.wins_r !== 3'(exp_wr)) $display("FAIL final_tick_tally: got %0d want %0d", bus.wins_r, exp_wr); else passed++;
      wait_show(ticks, gap, extra, ok);
      total++; if (!ok || extra) $display("FAIL final_tick_show: ok=%b extra=%b want 1/0", ok, extra); else passed++;
   endtask

   task automatic test_random_holdoff();
      int n, e, ticks, gap, lo, hi; bit last, clr_long, ok, extra;
      rand_zero = 1'b0;
      lo = 1000; hi = -1;
      for (int r = 0; r < 10; r++) begin
         wait_armed(n, e, last, clr_long, ok);
         total++; if (!ok || n !== e) $display("FAIL rand_holdoff: round %0d ok=%b got %0d want %0d", r, ok, n, e); else passed++;
         total++; if (n < MIN_WAIT || n > MIN_WAIT + (1 << RWAIT_BITS) - 1) $display("FAIL rand_range: got %0d want %0d..%0d", n, MIN_WAIT, MIN_WAIT + (1 << RWAIT_BITS) - 1); else passed++;
         if (n < lo) lo = n;
         if (n > hi) hi = n;
         pulse(1'b1, 1'b1);
         wait_show(ticks, gap, extra, ok);
      end
      total++; if (hi <= lo) $display("FAIL rand_spread: min %0d max %0d want differing", lo, hi); else passed++;
   endtask

   task automatic test_match();
      int n, e, ticks, gap; bit last, clr_long, ok, extra, seen, bad;
      logic [1:0] exp_led;
      int toggles;
      while (exp_wr < WIN_ROUNDS) begin
         wait_armed(n, e, last, clr_long, ok);
         pulse(1'b0, 1'b1);
         exp_wr++;
         total++; if (bus.wins_r !== 3'(exp_wr)) $display("FAIL match_tally: got %0d want %0d", bus.wins_r, exp_wr); else passed++;
         if (exp_wr < WIN_ROUNDS) wait_show(ticks, gap, extra, ok);
      end
      seen = 1'b0; bad = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         if (bus.match_over === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.clr !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      total++; if (!seen || bad) $display("FAIL match_over: seen=%b clr_seen=%b want 1/0", seen, bad); else passed++;
      total++; if (bus.winner_r !== 1'b1 || bus.led_ctrl !== 2'b11) $display("FAIL match_winner: winner_r=%b led=%b want 1/11", bus.winner_r, bus.led_ctrl); else passed++;
      exp_led = 2'b11;
      toggles = 0;
      for (int i = 0; i < 60; i++) begin
         total++; if (bus.led_ctrl !== exp_led) $display("FAIL over_flash: cycle %0d got %b want %b", i, bus.led_ctrl, exp_led); else passed++;
         total++; if ({bus.pt_l, bus.pt_r, bus.tie, bus.clr, bus.leds_on} !== 5'b0 || bus.wins_r !== 3'(WIN_ROUNDS) || bus.wins_l !== 3'(exp_wl) || bus.match_over !== 1'b1)
            $display("FAIL over_frozen: cycle %0d strobes %b wins %0d/%0d over %b", i, {bus.pt_l, bus.pt_r, bus.tie, bus.clr, bus.leds_on}, bus.wins_l, bus.wins_r, bus.match_over);
         else passed++;
         if (bus.slowen) begin
            exp_led = {1'b1, ~exp_led[0]};
            toggles++;
         end
         bus.push_l = 1'($urandom_range(0, 1));
         bus.push_r = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      bus.push_l = 1'b0;
      bus.push_r = 1'b0;
      total++; if (toggles < 2) $display("FAIL over_ticks: only %0d ticks seen want >=2", toggles); else passed++;
   endtask

   initial begin
      bus.push_l = 1'b0;
      bus.push_r = 1'b0;
      test_reset();
      test_armed_win();
      test_false_start();
      test_tie();
      test_reset_mid_armed();
      test_final_tick_false_start();
      test_random_holdoff();
      test_match();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
